// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the mult/div sequencer and its watchdog.
//   state_t         : sequencer FSM state encoding
//   OP_MULT/OP_DIV  : values of the latched operation bit (also the HI/LO
//                     mux select value for that operation)
//   DEFAULT_TIMEOUT : default watchdog limit in WAIT cycles
// Optional feature macro used by the sequencer: MULDIV_PERF_EN
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_EXC,
    ST_TOUT
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/muldiv_sequencer_wdog.sv
// -----------------------------------------------------------------------------
// muldiv_wdog
// Clearable up-counter with a terminal-count flag, used as the WAIT-state
// watchdog of the mult/div sequencer.
// Ports:
//   clk   in  system clock, rising edge
//   reset in  synchronous active-low reset
//   clr   in  clear the count to zero (wins over en)
//   en    in  count one cycle
//   tc    out high while the count equals TIMEOUT-1
// Parameters: TIMEOUT (>= 2), CNT_W (derived width, do not override)
// -----------------------------------------------------------------------------
module muldiv_wdog
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] r_count;
  logic             w_atLimit;

  // The terminal count is the last cycle the owner may still wait; the owner
  // leaves WAIT on that cycle, so the counter never needs to wrap.
  assign w_atLimit = (r_count == CNT_W'(TIMEOUT - 1));
  assign tc        = w_atLimit;

  // Counter: clear has priority so a fresh operation always starts at zero,
  // and counting holds at the terminal value instead of wrapping around.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !w_atLimit) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Runs one multiply or divide on the shared units for the multicycle CPU:
// pulses the selected unit's init, waits for its stop (under a watchdog),
// loads HI/LO through the mux, then reports done, divide-by-zero or timeout.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_op/divisor_zero in, req_ready/busy out : request handshake
//   mult_init out, mult_stop in                          : multiplier control
//   div_init out, div_stop/div_zero in                   : divider control
//   hilo_sel, hi_load, lo_load out                       : HI/LO write-back
//   done, exc_div0, timeout_err out                      : one-cycle results
//   perf_last_lat[15:0], perf_ops[15:0] out              : only with macro
// Optional feature macro: MULDIV_PERF_EN (adds the two perf outputs)
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic        divisor_zero,
  output logic        req_ready,
  output logic        busy,
  output logic        mult_init,
  input  logic        mult_stop,
  output logic        div_init,
  input  logic        div_stop,
  input  logic        div_zero,
  output logic        hilo_sel,
  output logic        hi_load,
  output logic        lo_load,
  output logic        done,
  output logic        exc_div0,
  output logic        timeout_err
`ifdef MULDIV_PERF_EN
  ,
  output logic [15:0] perf_last_lat,
  output logic [15:0] perf_ops
`endif
);

  state_t r_state;
  logic   r_op;
  logic   w_tc;
  logic   w_selStop;
  logic   w_divZeroHit;
  logic   w_enterWrite;

  // Only the unit we started is listened to; the divider's zero report only
  // matters while a divide is in flight.
  assign w_selStop    = (r_op == OP_DIV) ? div_stop : mult_stop;
  assign w_divZeroHit = (r_op == OP_DIV) && div_zero;
  assign w_enterWrite = (r_state == ST_WAIT) && !w_divZeroHit && w_selStop;

  // Watchdog: cleared while the init pulse is out, counts every WAIT cycle.
  muldiv_wdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wdog (
    .clk  (clk),
    .reset(reset),
    .clr  (r_state == ST_START),
    .en   (r_state == ST_WAIT),
    .tc   (w_tc)
  );

  // Main sequencer FSM. The op bit is latched at accept and kept through the
  // return to IDLE so the HI/LO mux select stays stable until the next accept.
  // A zero divisor caught at accept skips the divider entirely.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_state <= (req_op == OP_DIV && divisor_zero) ? ST_EXC : ST_START;
          end
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_divZeroHit) begin
            r_state <= ST_EXC;
          end else if (w_selStop) begin
            r_state <= ST_WRITE;
          end else if (w_tc) begin
            r_state <= ST_TOUT;
          end
        end
        ST_WRITE: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        ST_EXC:   r_state <= ST_IDLE;
        ST_TOUT:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs: everything is a decode of the state register and the
  // latched op, so no input ever reaches an output in the same cycle.
  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign mult_init   = (r_state == ST_START) && (r_op == OP_MULT);
  assign div_init    = (r_state == ST_START) && (r_op == OP_DIV);
  assign hilo_sel    = r_op;
  assign hi_load     = (r_state == ST_WRITE);
  assign lo_load     = (r_state == ST_WRITE);
  assign done        = (r_state == ST_DONE);
  assign exc_div0    = (r_state == ST_EXC);
  assign timeout_err = (r_state == ST_TOUT);

`ifdef MULDIV_PERF_EN
  logic [15:0] r_waitCnt;
  logic [15:0] r_lastLat;
  logic [15:0] r_ops;

  // Performance counters: r_waitCnt counts WAIT cycles of the current op; the
  // total including the cycle that saw stop is captured on entry to WRITE.
  // The DONE counter saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_waitCnt <= '0;
      r_lastLat <= '0;
      r_ops     <= '0;
    end else begin
      if (r_state == ST_START) begin
        r_waitCnt <= '0;
      end else if (r_state == ST_WAIT && r_waitCnt != 16'hFFFF) begin
        r_waitCnt <= r_waitCnt + 16'd1;
      end
      if (w_enterWrite) begin
        r_lastLat <= (r_waitCnt == 16'hFFFF) ? r_waitCnt : r_waitCnt + 16'd1;
      end
      if (r_state == ST_DONE && r_ops != 16'hFFFF) begin
        r_ops <= r_ops + 16'd1;
      end
    end
  end

  assign perf_last_lat = r_lastLat;
  assign perf_ops      = r_ops;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. Each issued operation pushes its
// expected outcome (kind and absolute cycle) to a scoreboard queue; a monitor
// pops and compares whenever the DUT raises done, exc_div0 or timeout_err.
// Per-cycle strobes are checked while each operation runs.
// Optional feature macro: MULDIV_PERF_EN (perf outputs are then checked too)
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int TB_TIMEOUT = 40;
  localparam logic [31:0] KIND_DONE = 32'd1;
  localparam logic [31:0] KIND_EXC  = 32'd2;
  localparam logic [31:0] KIND_TOUT = 32'd4;

  typedef struct {
    logic [31:0] kind;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_op = 1'b0;
  logic divisor_zero = 1'b0;
  logic mult_stop = 1'b0;
  logic div_stop = 1'b0;
  logic div_zero = 1'b0;
  logic req_ready, busy, mult_init, div_init, hilo_sel;
  logic hi_load, lo_load, done, exc_div0, timeout_err;
`ifdef MULDIV_PERF_EN
  logic [15:0] perf_last_lat, perf_ops;
  int expLat = 0;
  int expOps = 0;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cycleNum = 0;
  exp_t sbQ[$];

  muldiv_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .divisor_zero(divisor_zero),
    .req_ready   (req_ready),
    .busy        (busy),
    .mult_init   (mult_init),
    .mult_stop   (mult_stop),
    .div_init    (div_init),
    .div_stop    (div_stop),
    .div_zero    (div_zero),
    .hilo_sel    (hilo_sel),
    .hi_load     (hi_load),
    .lo_load     (lo_load),
    .done        (done),
    .exc_div0    (exc_div0),
    .timeout_err (timeout_err)
`ifdef MULDIV_PERF_EN
    ,
    .perf_last_lat(perf_last_lat),
    .perf_ops     (perf_ops)
`endif
  );

  // Free-running clock and a cycle counter used to timestamp results.
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // The single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual,
               expected, cycleNum);
    end
  endtask

  // Scoreboard monitor: every result pulse must match the oldest expectation
  // in both kind and cycle; a pulse with nothing expected is an error.
  always @(negedge clk) begin
    logic [31:0] obs;
    exp_t        e;
    obs = {29'd0, timeout_err, exc_div0, done};
    if (obs != 32'd0) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedResult", obs, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("resultKind", obs, e.kind);
        checkOutput("resultCycle", cycleNum, e.cyc);
      end
    end
  end

  // Waits (bounded) at a falling edge until the DUT is ready for a request.
  task automatic waitReady();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput("readyTimeout", 32'd0, 32'd1);
  endtask

  // Issues one operation and scripts the unit responses. stopRel is the cycle
  // (relative to the START cycle, so WAIT cycle k is rel k) where the selected
  // unit's stop is raised; -1 means never. zeroWithStop also raises div_zero in
  // that cycle; strayMult holds mult_stop high throughout a divide.
  task automatic applyStimulus(input logic op, input logic dz, input int stopRel,
                               input logic zeroWithStop, input logic strayMult);
    int          acc, endRel, loadRel;
    logic [31:0] kind;
    logic        precheck;
    precheck = op && dz;
    loadRel  = -1;
    if (precheck) begin
      kind = KIND_EXC;  endRel = 0;
    end else if (stopRel >= 1 && stopRel <= TB_TIMEOUT) begin
      if (op && zeroWithStop) begin
        kind = KIND_EXC;  endRel = stopRel + 1;
      end else begin
        kind = KIND_DONE; endRel = stopRel + 2; loadRel = stopRel + 1;
      end
    end else begin
      kind = KIND_TOUT; endRel = TB_TIMEOUT + 1;
    end
    waitReady();
    req_valid = 1'b1;
    req_op = op;
    divisor_zero = dz;
    @(posedge clk);
    #1;
    acc = cycleNum;
    sbQ.push_back('{kind, acc + endRel});
    for (int r = 0; r <= endRel + 1; r++) begin
      @(negedge clk);
      req_valid = 1'b0;
      divisor_zero = 1'b0;
      mult_stop = (!op && r == stopRel) || (strayMult && op && r >= 1);
      div_stop  = op && (r == stopRel);
      div_zero  = op && zeroWithStop && (r == stopRel);
      checkOutput("multInit", mult_init, r == 0 && !precheck && !op);
      checkOutput("divInit", div_init, r == 0 && !precheck && op);
      checkOutput("hiLoad", hi_load, r == loadRel);
      checkOutput("loLoad", lo_load, r == loadRel);
      checkOutput("busy", busy, r <= endRel);
      checkOutput("reqReady", req_ready, r > endRel);
      if (r == loadRel) checkOutput("hiloSel", hilo_sel, op);
    end
    mult_stop = 1'b0;
    div_stop = 1'b0;
    div_zero = 1'b0;
`ifdef MULDIV_PERF_EN
    if (kind == KIND_DONE) begin
      expLat = stopRel;
      expOps++;
    end
    checkOutput("perfLastLat", perf_last_lat, expLat);
    checkOutput("perfOps", perf_ops, expOps);
`endif
  endtask

  // Safety net: the bench must never hang.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    int acc;

    // Reset state: only req_ready is high, mux select starts at 0.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReady", req_ready, 1'b1);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstStrobes", {mult_init, div_init, hi_load, lo_load, done,
                               exc_div0, timeout_err, hilo_sel}, 8'd0);
    reset = 1'b1;

    // Mult with stop in WAIT cycle 32, then boundary stops at first and last
    // WAIT cycle (stop beats the watchdog on its terminal cycle).
    applyStimulus(1'b0, 1'b0, 32, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, TB_TIMEOUT, 1'b0, 1'b0);
    // Divide-by-zero precheck, then stop/zero conflict resolved as exception.
    applyStimulus(1'b1, 1'b1, -1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5, 1'b1, 1'b0);
    // Watchdog on a divide with a stray multiplier stop held high throughout.
    applyStimulus(1'b1, 1'b0, -1, 1'b0, 1'b1);
    // Plain divide, checks hilo_sel = 1 at the load.
    applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0);

    // Reset mid-WAIT of a divide: everything returns to idle, later stops and
    // zero reports are ignored, and the op latch goes back to 0.
    waitReady();
    req_valid = 1'b1;
    req_op = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r <= 8; r++) begin
      @(negedge clk);
      req_valid = 1'b0;
      reset = (r == 3) ? 1'b0 : 1'b1;
      mult_stop = (r == 4 || r == 5);
      div_stop = (r == 4 || r == 5);
      div_zero = (r == 5);
      if (r >= 4) begin
        checkOutput("midRstReady", req_ready, 1'b1);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstSel", hilo_sel, 1'b0);
        checkOutput("midRstLoad", {hi_load, lo_load, div_init}, 3'd0);
      end
    end
    mult_stop = 1'b0;
    div_stop = 1'b0;
    div_zero = 1'b0;
`ifdef MULDIV_PERF_EN
    expLat = 0;
    expOps = 0;
    checkOutput("perfRstLat", perf_last_lat, expLat);
    checkOutput("perfRstOps", perf_ops, expOps);
`endif

    // Back-to-back: req_valid held high, op switches to div right after the
    // first accept. Second accept lands in the IDLE cycle after done (rel 6),
    // and hilo_sel switches only then.
    waitReady();
    req_valid = 1'b1;
    req_op = 1'b0;
    @(posedge clk);
    #1;
    acc = cycleNum;
    sbQ.push_back('{KIND_DONE, acc + 5});
    sbQ.push_back('{KIND_DONE, acc + 11});
    for (int r = 0; r <= 12; r++) begin
      @(negedge clk);
      req_op = 1'b1;
      req_valid = (r <= 6);
      mult_stop = (r == 3);
      div_stop = (r == 9);
      checkOutput("b2bSel", hilo_sel, r >= 7);
      checkOutput("b2bReady", req_ready, r == 6 || r == 12);
      checkOutput("b2bMultInit", mult_init, r == 0);
      checkOutput("b2bDivInit", div_init, r == 7);
      checkOutput("b2bLoad", hi_load, r == 4 || r == 10);
    end
    req_valid = 1'b0;
    mult_stop = 1'b0;
    div_stop = 1'b0;
`ifdef MULDIV_PERF_EN
    expLat = 2;
    expOps = 2;
    checkOutput("perfB2bLat", perf_last_lat, expLat);
    checkOutput("perfB2bOps", perf_ops, expOps);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", sbQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
